predictor_gshare_param: RTL and testbench
=========================================

// Module: predictor_gshare_param
// PURPOSE
//  Parametrised two-level direction predictor; successor to the fixed 2-bit-history / 4-bank / 2-bit-counter predictor.
//  Global history length, table depth, counter width and index mode (GAp concat / gshare XOR) are parameters.
//  Table is cleared by a reset-sweep FSM instead of per-entry async reset; EX updates are pipelined read-modify-write with forwarding.
//  Sits between IF (next_pc lookup) and EX (resolved branch update); loop branches are excluded as they are owned by the loop predictor.
// PARAMETERS
//  ENTRY_NUM      256                  table entries, power of 2, >=4
//  PR_ADDR_WIDTH  $clog2(ENTRY_NUM)    table index width
//  HIST_LEN       4                    global history bits, 1..PR_ADDR_WIDTH
//  CNT_WIDTH      2                    saturating counter width, 2..4
//  INDEX_MODE     1                    0 = GAp {hist, pc[PR_ADDR_WIDTH-HIST_LEN+1:2]}; 1 = gshare pc[PR_ADDR_WIDTH+1:2] ^ zext(hist)
// PORTS
//  cpu_clk          in   1                   core clock
//  cpu_rstn         in   1                   asynchronous active-low reset
//  branch_ex        in   1                   resolved conditional branch in EX this cycle
//  is_loop_ex       in   1                   EX branch is a loop branch (no update)
//  branch_taken_ex  in   1                   resolved direction of EX branch
//  next_pc          in   `ADDR_WIDTH         IF lookup address
//  branch_pc_ex     in   `ADDR_WIDTH         address of EX branch
//  pred_ready       out  1                   table initialised, predictions valid
//  predict_taken    out  1                   predicted direction for next_pc
//  predict_strong   out  1                   counter saturated (0 or max)
// BEHAVIOUR
//  upd = branch_ex & !is_loop_ex & pred_ready. Loop branches and branches during INIT change nothing.
//  History: ghr[HIST_LEN-1:0] reset 0; on upd, ghr <= {ghr[HIST_LEN-2:0], branch_taken_ex} (HIST_LEN=1: ghr <= taken).
//  Index: ridx from next_pc + current ghr; uidx from branch_pc_ex + ghr value BEFORE this cycle's shift. Same formula for both.
//  FSM: INIT -> RUN. Reset enters INIT, sweep counter 0. INIT writes WNT = 2^(CNT_WIDTH-1)-1 to entry sweep, one per cycle.
//   INIT: last entry (ENTRY_NUM-1) written -> RUN. pred_ready=1 from the first cycle in RUN, i.e. ENTRY_NUM cycles after reset release.
//   RUN is terminal until reset. Async reset at any time (incl. mid-INIT) restarts INIT at entry 0, ghr=0, drops pending write.
//  Update pipeline, stage U1 (upd cycle N): read old = fwd ? wr_cnt_q : tbl[uidx].
//   new = taken ? (old==MAX ? MAX : old+1) : (old==0 ? 0 : old-1); register wr_vld_q, wr_idx_q=uidx, wr_cnt_q=new.
//  Update pipeline, stage U2 (cycle N+1): tbl[wr_idx_q] <= wr_cnt_q. Back-to-back upd every cycle supported, no stall.
//   fwd = wr_vld_q & (wr_idx_q==uidx); this makes consecutive updates to one index compound correctly.
//  Read: combinational. cnt = (wr_vld_q & wr_idx_q==ridx) ? wr_cnt_q : tbl[ridx]. Read sees pending write (bypass).
//   predict_taken = cnt[CNT_WIDTH-1] & pred_ready; predict_strong = (cnt==0 | cnt==MAX) & pred_ready.
//   Both outputs are 0 while pred_ready=0 (and at reset).
//  Reset values: pred_ready=0, predict_taken=0, predict_strong=0, ghr=0, wr_vld_q=0, sweep=0; table contents are not reset (swept).
//  Width rules: counters never wrap; INDEX_MODE 1 zero-extends ghr to PR_ADDR_WIDTH; upper next_pc bits above PR_ADDR_WIDTH+1 are ignored (aliasing allowed).
//  Simultaneous upd and read to same index: read returns the pre-update value (or the U2 bypass value), never the U1 result.
// TESTING
//  T1 sweep: release rstn -> pred_ready=0 for exactly 256 cycles then 1; all 256 indices read cnt=1 (taken=0, strong=0).
//  T2 saturation (mode 1, HIST_LEN 4): pc 0x100 taken x4 -> ghr=4'hF; 3 more taken -> tbl[0x40^0xF=0x4F] = 2,3,3.
//   T2 cont.: predict_taken=1, strong=1 for next_pc=0x100 after the 2nd of those updates.
//  T3 forwarding: two back-to-back upd, same uidx, taken,taken from cnt=1 -> entry 3 (no lost update).
//   T3 cont.: read of that idx in the cycle after the first returns 2 via bypass.
//  T4 loop exclusion: is_loop_ex=1 with branch_ex=1 for 10 cycles -> ghr and table unchanged.
//  T5 reset mid-INIT: assert cpu_rstn=0 at sweep=100 -> after release, full 256-cycle sweep again.
//   T5 cont.: upd during INIT ignored, ghr stays 0.
//  T6 GAp mode (INDEX_MODE 0, HIST_LEN 2): ghr=2'b10, branch_pc_ex=0x104 -> only entry {2'b10,6'h01}=0x81 changes; CNT_WIDTH=3 saturates at 7 and 0.

Source files
------------

// File: rtl/predictor_gshare_param.sv
// Two-level (GAp/gshare) direction predictor; combinational lookup, EX updates via 2-stage read-modify-write with forwarding.
// No backpressure: one update per cycle is always accepted; pred_ready gates outputs until the reset sweep has cleared the table.
module predictor_gshare_param #(
  parameter int ADDR_WIDTH    = 32,
  parameter int ENTRY_NUM     = 256,
  parameter int PR_ADDR_WIDTH = $clog2(ENTRY_NUM),
  parameter int HIST_LEN      = 4,
  parameter int CNT_WIDTH     = 2,
  parameter int INDEX_MODE    = 1
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  branch_ex,
  input  logic                  is_loop_ex,
  input  logic                  branch_taken_ex,
  input  logic [ADDR_WIDTH-1:0] next_pc,
  input  logic [ADDR_WIDTH-1:0] branch_pc_ex,
  output logic                  pred_ready,
  output logic                  predict_taken,
  output logic                  predict_strong
);

  localparam logic [CNT_WIDTH-1:0]     CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0]     CNT_WNT  = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);
  localparam logic [PR_ADDR_WIDTH-1:0] PC_MASK  = {PR_ADDR_WIDTH{1'b1}} >> HIST_LEN;
  localparam logic [PR_ADDR_WIDTH-1:0] LAST_IDX = PR_ADDR_WIDTH'(ENTRY_NUM - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                   state;
  logic [PR_ADDR_WIDTH-1:0] sweep;
  logic [HIST_LEN-1:0]      ghr;
  logic [CNT_WIDTH-1:0]     tbl [ENTRY_NUM];

  logic                     wr_vld_q;
  logic [PR_ADDR_WIDTH-1:0] wr_idx_q;
  logic [CNT_WIDTH-1:0]     wr_cnt_q;

  logic                     upd;
  logic [PR_ADDR_WIDTH-1:0] ridx;
  logic [PR_ADDR_WIDTH-1:0] uidx;
  logic [CNT_WIDTH-1:0]     old_cnt;
  logic [CNT_WIDTH-1:0]     new_cnt;
  logic [CNT_WIDTH-1:0]     rd_cnt;
  logic                     unused_pc_bits;

  // GAp places history above the low pc bits; gshare folds zero-extended history into them.
  function automatic logic [PR_ADDR_WIDTH-1:0] tbl_idx(input logic [PR_ADDR_WIDTH-1:0] pc_bits,
                                                       input logic [HIST_LEN-1:0]      hist);
    logic [PR_ADDR_WIDTH-1:0] hist_z;
    hist_z = PR_ADDR_WIDTH'(hist);
    if (INDEX_MODE == 0)
      tbl_idx = (hist_z << (PR_ADDR_WIDTH - HIST_LEN)) | (pc_bits & PC_MASK);
    else
      tbl_idx = pc_bits ^ hist_z;
  endfunction

  assign upd  = branch_ex & ~is_loop_ex & pred_ready;
  assign ridx = tbl_idx(next_pc[PR_ADDR_WIDTH+1:2], ghr);
  assign uidx = tbl_idx(branch_pc_ex[PR_ADDR_WIDTH+1:2], ghr);

  assign unused_pc_bits = ^{next_pc[ADDR_WIDTH-1:PR_ADDR_WIDTH+2], next_pc[1:0],
                            branch_pc_ex[ADDR_WIDTH-1:PR_ADDR_WIDTH+2], branch_pc_ex[1:0]};

  always_comb begin
    old_cnt = (wr_vld_q && (wr_idx_q == uidx)) ? wr_cnt_q : tbl[uidx];
    new_cnt = old_cnt;
    if (branch_taken_ex) begin
      if (old_cnt != CNT_MAX) new_cnt = old_cnt + 1'b1;
    end else begin
      if (old_cnt != '0) new_cnt = old_cnt - 1'b1;
    end
    rd_cnt = (wr_vld_q && (wr_idx_q == ridx)) ? wr_cnt_q : tbl[ridx];
  end

  assign predict_taken  = rd_cnt[CNT_WIDTH-1] & pred_ready;
  assign predict_strong = ((rd_cnt == '0) | (rd_cnt == CNT_MAX)) & pred_ready;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state      <= S_INIT;
      sweep      <= '0;
      pred_ready <= 1'b0;
    end else if (state == S_INIT) begin
      if (sweep == LAST_IDX) begin
        state      <= S_RUN;
        pred_ready <= 1'b1;
      end else begin
        sweep <= sweep + 1'b1;
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      ghr      <= '0;
      wr_vld_q <= 1'b0;
      wr_idx_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      wr_vld_q <= upd;
      if (upd) begin
        ghr      <= HIST_LEN'({ghr, branch_taken_ex});
        wr_idx_q <= uidx;
        wr_cnt_q <= new_cnt;
      end
    end
  end

  // Storage has no reset; the INIT sweep and the U2 commit share one write port.
  always_ff @(posedge cpu_clk) begin
    if (state == S_INIT)
      tbl[sweep] <= CNT_WNT;
    else if (wr_vld_q)
      tbl[wr_idx_q] <= wr_cnt_q;
  end

endmodule

// File: tb/tb_predictor_gshare_param.sv
// Bench for predictor_gshare_param: a gshare instance (HIST 4, 2-bit) and a GAp instance (HIST 2, 3-bit) share clock and reset.
module tb_predictor_gshare_param;

  typedef struct {
    bit          sel;
    bit          br;
    bit          lp;
    bit          tk;
    logic [31:0] bpc;
    logic [31:0] npc;
    bit          et;
    bit          es;
  } vec_t;

  typedef struct {
    bit et;
    bit es;
    int id;
  } exp_t;

  logic        cpu_clk;
  logic        cpu_rstn;
  logic        br1, lp1, tk1, br2, lp2, tk2;
  logic [31:0] bpc1, npc1, bpc2, npc2;
  logic        rdy1, pt1, ps1, rdy2, pt2, ps2;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks;
  int   errors;
  int   s_t5, s_t6;

  predictor_gshare_param dut1 (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .branch_ex(br1), .is_loop_ex(lp1),
    .branch_taken_ex(tk1), .next_pc(npc1), .branch_pc_ex(bpc1),
    .pred_ready(rdy1), .predict_taken(pt1), .predict_strong(ps1)
  );

  predictor_gshare_param #(.HIST_LEN(2), .CNT_WIDTH(3), .INDEX_MODE(0)) dut2 (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .branch_ex(br2), .is_loop_ex(lp2),
    .branch_taken_ex(tk2), .next_pc(npc2), .branch_pc_ex(bpc2),
    .pred_ready(rdy2), .predict_taken(pt2), .predict_strong(ps2)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input bit sel, input bit br, input bit lp, input bit tk,
                     input logic [31:0] bpc, input logic [31:0] npc, input bit et, input bit es);
    vecs.push_back('{sel, br, lp, tk, bpc, npc, et, es});
  endtask

  task automatic idle();
    br1 = 0; lp1 = 0; tk1 = 0; bpc1 = 0; npc1 = 0;
    br2 = 0; lp2 = 0; tk2 = 0; bpc2 = 0; npc2 = 0;
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  // Counts clock edges from reset release until dut1 reports ready.
  task automatic count_ready(output int n);
    n = 0;
    do begin
      tick();
      n++;
      if (n == 10) begin
        chk("init_gate_taken1", pt1, 0);
        chk("init_gate_strong1", ps1, 0);
        chk("init_gate_strong2", ps2, 0);
      end
    end while (!rdy1 && n < 1000);
  endtask

  task automatic run_vecs(input int first, input int last);
    exp_t e;
    for (int i = first; i < last; i++) begin
      tick();
      idle();
      if (vecs[i].sel) begin
        br2 = vecs[i].br; lp2 = vecs[i].lp; tk2 = vecs[i].tk;
        bpc2 = vecs[i].bpc; npc2 = vecs[i].npc;
      end else begin
        br1 = vecs[i].br; lp1 = vecs[i].lp; tk1 = vecs[i].tk;
        bpc1 = vecs[i].bpc; npc1 = vecs[i].npc;
      end
      sb.push_back('{vecs[i].et, vecs[i].es, i});
      @(negedge cpu_clk);
      e = sb.pop_front();
      chk($sformatf("vec%0d_taken", e.id), vecs[e.id].sel ? pt2 : pt1, e.et);
      chk($sformatf("vec%0d_strong", e.id), vecs[e.id].sel ? ps2 : ps1, e.es);
    end
    tick();
    idle();
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;

    // T2 saturation, gshare idx = pc[9:2] ^ ghr
    add(0,1,0,1,'h100,'h100,0,0);
    add(0,1,0,1,'h100,'h104,1,0);
    add(0,1,0,1,'h100,'h108,1,0);
    add(0,1,0,1,'h100,'h110,1,0);
    add(0,1,0,1,'h100,'h120,1,0);
    add(0,1,0,1,'h100,'h100,1,0);
    add(0,1,0,1,'h100,'h100,1,1);
    add(0,0,0,0,'h000,'h100,1,1);
    add(0,0,0,0,'h000,'h100,1,1);
    // T3 forwarding on entry 0x8F, then decrement and floor on 0xCE
    add(0,1,0,1,'h200,'h200,0,0);
    add(0,1,0,1,'h200,'h200,1,0);
    add(0,0,0,0,'h000,'h200,1,1);
    add(0,0,0,0,'h000,'h200,1,1);
    add(0,1,0,0,'h200,'h200,1,1);
    add(0,0,0,0,'h000,'h204,1,0);
    add(0,1,0,0,'h300,'h204,1,0);
    add(0,0,0,0,'h000,'h308,0,1);
    add(0,1,0,0,'h308,'h308,0,1);
    add(0,0,0,0,'h000,'h318,0,1);
    // T4 loop branches leave ghr and table alone
    for (int k = 0; k < 10; k++) add(0,1,1,1,'h318,'h318,0,1);
    add(0,0,0,0,'h000,'h318,0,1);
    s_t5 = vecs.size();
    // T5 after mid-INIT reset: table re-swept, ghr back to 0
    add(0,0,0,0,'h000,'h13C,0,0);
    add(0,1,0,1,'h100,'h100,0,0);
    add(0,0,0,0,'h000,'h104,1,0);
    s_t6 = vecs.size();
    // T6 GAp on dut2, idx = {ghr, pc[7:2]}, 3-bit counters from 3
    add(1,1,0,1,'h0FC,'h0FC,0,0);
    add(1,1,0,0,'h0FC,'h0FC,0,0);
    for (int k = 1; k <= 5; k++) begin
      add(1,1,0,1,'h104,'h104, k >= 2, k == 5);
      add(1,1,0,0,'h0FC,'h0FC, 0, k >= 3);
    end
    add(1,0,0,0,'h000,'h104,1,1);
    add(1,0,0,0,'h000,'h108,0,0);
    add(1,0,0,0,'h000,'h100,0,0);

    idle();
    cpu_rstn = 1'b0;
    repeat (3) tick();
    br1 = 1; tk1 = 1; br2 = 1; tk2 = 1;
    tick();
    chk("reset_ready1", rdy1, 0);
    chk("reset_taken1", pt1, 0);
    chk("reset_strong1", ps1, 0);
    chk("reset_ready2", rdy2, 0);
    chk("reset_strong2", ps2, 0);
    idle();

    // T1 sweep length and swept contents
    cpu_rstn = 1'b1;
    count_ready(n);
    chk("t1_sweep_cycles", n, 256);
    chk("t1_ready2", rdy2, 1);
    for (int i = 0; i < 256; i++) begin
      npc1 = 32'(i) << 2;
      npc2 = 32'(i) << 2;
      @(negedge cpu_clk);
      chk($sformatf("t1_idx%0d_taken1", i), pt1, 0);
      chk($sformatf("t1_idx%0d_strong1", i), ps1, 0);
      chk($sformatf("t1_idx%0d_taken2", i), pt2, 0);
      chk($sformatf("t1_idx%0d_strong2", i), ps2, 0);
      tick();
    end
    idle();

    run_vecs(0, s_t5);

    // T5 reset at sweep=100, then a full sweep with updates offered throughout
    cpu_rstn = 1'b0;
    #2;
    cpu_rstn = 1'b1;
    repeat (100) tick();
    chk("t5_mid_init_ready", rdy1, 0);
    cpu_rstn = 1'b0;
    #2;
    chk("t5_reset_ready", rdy1, 0);
    tick();
    br1 = 1; tk1 = 1; bpc1 = 'h100;
    br2 = 1; tk2 = 1; bpc2 = 'h104;
    cpu_rstn = 1'b1;
    count_ready(n);
    idle();
    chk("t5_sweep_cycles", n, 256);

    run_vecs(s_t5, s_t6);
    run_vecs(s_t6, vecs.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
